// File: rtl/lfsr_sym_pkg.sv
// lfsr_sym_pkg: shared types and helpers for the LFSR symbol source.
//   sym_fsm_e  : run/idle control state of the symbol source
//   lfsr_step  : one right-shift Fibonacci LFSR step on a zero-extended state
//   LFSR_MAX_W : widest LFSR the helper supports (state/taps are padded to it)
package lfsr_sym_pkg;

  localparam int LFSR_MAX_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sym_fsm_e;

  // Shift right by one; the new MSB (bit width-1) is the parity of the
  // tapped bits. Bits at and above 'width' must be zero in both operands.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps,
    input int                    width
  );
    logic [LFSR_MAX_W-1:0] nxt;
    nxt = (state >> 1) | (LFSR_MAX_W'(^(state & taps)) << (width - 1));
    return nxt;
  endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// rate_tick_gen: programmable rate divider producing a one-cycle enable pulse
// every max(rate_limit,1) cycles while 'run' is high.
//   clk, reset  : clock, asynchronous active-high reset
//   run         : count enable; low clears the counter and blocks ticks
//   rate_limit  : cycles per tick, 0 behaves as 1
//   tick        : one-cycle pulse on the last cycle of each period
module rate_tick_gen #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] rate_limit,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count_q;
  logic [DIV_WIDTH-1:0] last;

  // Terminal count; rate_limit of 0 and 1 both mean "every cycle".
  assign last = (rate_limit == '0) ? '0 : rate_limit - DIV_WIDTH'(1);

  // >= rather than == so a limit lowered below the running count fires
  // immediately instead of wrapping the whole counter.
  assign tick = run && (count_q >= last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count_q <= '0;
    else if (!run)  count_q <= '0;
    else if (tick)  count_q <= '0;
    else            count_q <= count_q + DIV_WIDTH'(1);
  end

endmodule

// File: rtl/lfsr_symbol_source.sv
// lfsr_symbol_source: pseudo-random M-ary symbol source on a single clock.
// Every rate tick the LFSR advances SYM_BITS steps and the low SYM_BITS of
// the new state are offered on a valid/ready output.
//   clk, reset     : clock, asynchronous active-high reset
//   enable         : run symbol generation
//   rate_limit     : clk cycles per symbol (0 treated as 1)
//   seed_load/seed : one-cycle strobe loading the LFSR (0 -> INIT_VAL + lockup_err)
//   sym_ready      : consumer accepts the current symbol
//   sym_valid/data : symbol output
//   lfsr_state     : current LFSR register
//   overrun_count  : saturating count of symbols dropped while output was full
//   lockup_err     : sticky flag, an all-zero seed was attempted
module lfsr_symbol_source
  import lfsr_sym_pkg::*;
#(
  parameter int                    LFSR_WIDTH = 5,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = 5'b00101,
  parameter logic [LFSR_WIDTH-1:0] INIT_VAL   = 5'b00001,
  parameter int                    SYM_BITS   = 2,
  parameter int                    DIV_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  rate_limit,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic                  sym_ready,
  output logic                  sym_valid,
  output logic [SYM_BITS-1:0]   sym_data,
  output logic [LFSR_WIDTH-1:0] lfsr_state,
  output logic [15:0]           overrun_count,
  output logic                  lockup_err
);

  localparam logic [LFSR_MAX_W-1:0] TAPS_W = LFSR_MAX_W'(TAPS);
  localparam logic [LFSR_MAX_W-1:0] INIT_W = LFSR_MAX_W'(INIT_VAL);

  sym_fsm_e              state_q, state_d;
  logic                  run;
  logic                  tick;
  logic [LFSR_WIDTH-1:0] lfsr_adv;
  logic                  seed_zero;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Seed load drops 'run' for one cycle, which both clears the rate counter
  // and suppresses that cycle's tick without touching the FSM state.
  always_comb begin
    run = 1'b0;
    case (state_q)
      RUN:     run = enable && !seed_load;
      default: run = 1'b0;
    endcase
  end

  rate_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_rate (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .rate_limit (rate_limit),
    .tick       (tick)
  );

  // ---------------- LFSR unroll ----------------
  // SYM_BITS steps per tick; a zero state (only reachable through a bad
  // parameter set or upset) recovers to INIT_VAL on the next step.
  always_comb begin
    logic [LFSR_MAX_W-1:0] s;
    s = '0;
    s[LFSR_WIDTH-1:0] = lfsr_state;
    for (int i = 0; i < SYM_BITS; i++) begin
      if (s == '0) s = INIT_W;
      else         s = lfsr_step(s, TAPS_W, LFSR_WIDTH);
    end
    lfsr_adv = s[LFSR_WIDTH-1:0];
  end

  assign seed_zero = (seed == '0);

  // ---------------- LFSR / output register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_state    <= INIT_VAL;
      sym_valid     <= 1'b0;
      sym_data      <= '0;
      overrun_count <= '0;
      lockup_err    <= 1'b0;
    end else if (seed_load) begin
      lfsr_state <= seed_zero ? INIT_VAL : seed;
      sym_valid  <= 1'b0;
      if (seed_zero) lockup_err <= 1'b1;
    end else if (tick) begin
      lfsr_state <= lfsr_adv;
      // Output slot is free if empty or being drained this very cycle.
      if (!sym_valid || sym_ready) begin
        sym_data  <= lfsr_adv[SYM_BITS-1:0];
        sym_valid <= 1'b1;
      end else if (overrun_count != 16'hFFFF) begin
        overrun_count <= overrun_count + 16'd1;
      end
    end else if (sym_valid && sym_ready) begin
      sym_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_symbol_source.sv
// Self-checking bench for lfsr_symbol_source: directed scenarios plus a
// randomized run, all compared against a behavioural model of the spec.
module tb_lfsr_symbol_source;

  localparam int          W    = 5;
  localparam int unsigned TP   = 5'b00101;
  localparam int unsigned INIT = 5'b00001;
  localparam int          SB   = 2;
  localparam int          DW   = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] rate_limit = '0;
  logic          seed_load = 1'b0;
  logic [W-1:0]  seed = '0;
  logic          sym_ready = 1'b0;
  logic          sym_valid;
  logic [SB-1:0] sym_data;
  logic [W-1:0]  lfsr_state;
  logic [15:0]   overrun_count;
  logic          lockup_err;

  lfsr_symbol_source #(
    .LFSR_WIDTH (W), .TAPS (5'b00101), .INIT_VAL (5'b00001),
    .SYM_BITS (SB), .DIV_WIDTH (DW)
  ) dut (
    .clk (clk), .reset (reset), .enable (enable), .rate_limit (rate_limit),
    .seed_load (seed_load), .seed (seed), .sym_ready (sym_ready),
    .sym_valid (sym_valid), .sym_data (sym_data), .lfsr_state (lfsr_state),
    .overrun_count (overrun_count), .lockup_err (lockup_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_run;
  int unsigned m_cnt, m_lfsr, m_d, m_ovr;
  bit          m_v, m_lock;

  function automatic int unsigned m_step(input int unsigned s);
    if (s == 0) return INIT;
    return (s >> 1) | ((($countones(s & TP)) & 1) << (W - 1));
  endfunction

  task automatic mreset();
    m_run = 0; m_cnt = 0; m_lfsr = INIT; m_d = 0; m_ovr = 0; m_v = 0; m_lock = 0;
  endtask

  task automatic compare_all();
    chk("sym_valid", sym_valid, m_v);
    chk("sym_data", sym_data, m_d);
    chk("lfsr_state", lfsr_state, m_lfsr);
    chk("overrun_count", overrun_count, m_ovr);
    chk("lockup_err", lockup_err, m_lock);
  endtask

  // One clock: advance the model with the inputs the edge will see, then
  // compare after the edge.
  task automatic cyc();
    int unsigned eff;
    bit act, tk;
    eff = (rate_limit == 0) ? 1 : rate_limit;
    act = m_run && enable && !seed_load;
    tk  = act && (m_cnt >= eff - 1);
    if (seed_load) begin
      m_lfsr = (seed == 0) ? INIT : seed;
      if (seed == 0) m_lock = 1;
      m_v = 0;
    end else if (tk) begin
      for (int i = 0; i < SB; i++) m_lfsr = m_step(m_lfsr);
      if (!m_v || sym_ready) begin
        m_d = m_lfsr % (1 << SB);
        m_v = 1;
      end else if (m_ovr < 16'hFFFF) begin
        m_ovr++;
      end
    end else if (m_v && sym_ready) begin
      m_v = 0;
    end
    m_cnt = (act && !tk) ? m_cnt + 1 : 0;
    m_run = enable;
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; seed_load = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    mreset();
  endtask

  int unsigned exp_lfsr [3] = '{5'b01000, 5'b10010, 5'b10100};
  int unsigned exp_data [3] = '{2'b00, 2'b10, 2'b00};
  int unsigned rl_pick  [6] = '{0, 1, 2, 3, 4, 7};
  logic [SB-1:0] held;

  initial begin
    mreset();
    #7;
    do_reset();
    compare_all();
    chk("reset_lfsr", lfsr_state, 5'b00001);
    chk("reset_valid", sym_valid, 1'b0);

    // 1: rate 4, ready high: symbol every 4 cycles, known sequence.
    rate_limit = 4; sym_ready = 1; enable = 1;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      if (k == 5 || k == 9 || k == 13) begin
        chk("t1_valid", sym_valid, 1'b1);
        chk("t1_lfsr", lfsr_state, exp_lfsr[(k-5)/4]);
        chk("t1_data", sym_data, exp_data[(k-5)/4]);
      end
      if (k == 6 || k == 7) chk("t1_gap", sym_valid, 1'b0);
    end

    // 2: rate 1, 31 ticks: full period returns to INIT.
    do_reset();
    rate_limit = 1; sym_ready = 1; enable = 1;
    for (int k = 0; k < 32; k++) cyc();
    chk("t2_period", lfsr_state, 5'b00001);
    chk("t2_overrun", overrun_count, 16'd0);

    // 3: ready low, rate 2, 10 ticks: first symbol held, 9 dropped.
    do_reset();
    rate_limit = 2; sym_ready = 0; enable = 1;
    for (int k = 0; k < 3; k++) cyc();
    held = sym_data;
    for (int k = 0; k < 18; k++) cyc();
    chk("t3_overrun", overrun_count, 16'd9);
    chk("t3_held", sym_data, held);
    chk("t3_valid", sym_valid, 1'b1);
    sym_ready = 1;
    cyc();
    chk("t3_drain", sym_valid, 1'b0);
    cyc();
    chk("t3_reload", sym_valid, 1'b1);

    // 4: zero seed mid-run.
    do_reset();
    rate_limit = 3; sym_ready = 1; enable = 1;
    for (int k = 0; k < 7; k++) cyc();
    seed = 0; seed_load = 1;
    cyc();
    seed_load = 0;
    chk("t4_lfsr", lfsr_state, 5'b00001);
    chk("t4_lock", lockup_err, 1'b1);
    chk("t4_valid", sym_valid, 1'b0);
    for (int k = 0; k < 5; k++) cyc();
    seed = 5'b10110; seed_load = 1;
    cyc();
    seed_load = 0;
    chk("t4_sticky", lockup_err, 1'b1);
    for (int k = 0; k < 8; k++) cyc();

    // 5: limit lowered mid-count, then 0.
    do_reset();
    rate_limit = 100; sym_ready = 1; enable = 1;
    for (int k = 0; k < 51; k++) cyc();
    chk("t5_quiet", sym_valid, 1'b0);
    rate_limit = 3;
    cyc();
    chk("t5_early_tick", sym_valid, 1'b1);
    for (int k = 0; k < 9; k++) cyc();
    rate_limit = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("t5_rate0", sym_valid, 1'b1);
    end

    // 6: asynchronous reset mid-symbol.
    do_reset();
    rate_limit = 1; sym_ready = 0; enable = 1;
    for (int k = 0; k < 7; k++) cyc();
    chk("t6_pre_ovr", overrun_count, 16'd5);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", sym_valid, 1'b0);
    chk("t6_data", sym_data, 2'b00);
    chk("t6_lfsr", lfsr_state, 5'b00001);
    chk("t6_ovr", overrun_count, 16'd0);
    chk("t6_lock", lockup_err, 1'b0);
    enable = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    mreset();
    for (int k = 0; k < 10; k++) cyc();

    // Randomized run.
    do_reset();
    rate_limit = 2; enable = 1;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 19) == 0) rate_limit = rl_pick[$urandom_range(0, 5)];
      enable    = ($urandom_range(0, 9) != 0);
      sym_ready = ($urandom_range(0, 2) != 0);
      seed_load = ($urandom_range(0, 39) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 31));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lfsr_symbol_source.md
Name: lfsr_symbol_source

Overview:
Parametrised pseudo-random symbol source for the modulator datapath. It is the successor to the fixed 5-bit LFSR plus divided-clock scheme.
- Runs entirely on clk and replaces the slow clock with a programmable symbol-rate tick, so no clock-domain crossing is needed.
- Each tick advances the LFSR by SYM_BITS steps and presents one SYM_BITS-wide symbol on a valid/ready handshake.
- Drives modulating_bits of the carrier modulator, or any future M-ary modulator.

Parameters:
LFSR_WIDTH, 5, LFSR register width (>=3).
TAPS, 5'b00101, feedback mask: new MSB = XOR of state bits where TAPS=1; state shifts right.
INIT_VAL, 5'b00001, value loaded on reset and on lockup recovery; must be nonzero.
SYM_BITS, 2, bits per symbol (1..LFSR_WIDTH).
DIV_WIDTH, 32, width of the rate counter and rate_limit.

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
enable  in  1  run symbol generation
rate_limit  in  DIV_WIDTH  clk cycles per symbol tick; 0 is treated as 1
seed_load  in  1  one-cycle strobe: load seed
seed  in  LFSR_WIDTH  seed value
sym_ready  in  1  consumer accepts symbol
sym_valid  out  1  symbol available
sym_data  out  SYM_BITS  symbol = lfsr_state[SYM_BITS-1:0] at generation
lfsr_state  out  LFSR_WIDTH  current LFSR register
overrun_count  out  16  symbols dropped while the output was full (saturating)
lockup_err  out  1  sticky: an all-zero seed was attempted

Behaviour:
Reset:
- FSM=IDLE, lfsr=INIT_VAL, counter=0.
- sym_valid=0, sym_data=0, overrun_count=0, lockup_err=0.

FSM states:
- IDLE: counter held at 0, no ticks. A pending sym_valid remains until it is consumed.
- IDLE->RUN when enable=1.
- RUN: counter increments each cycle.
- tick = (counter >= eff_limit-1), where eff_limit = max(rate_limit,1). Using >= handles a limit lowered mid-count.
- On tick the counter returns to 0.
- RUN->IDLE when enable=0. The counter clears and no tick fires in that cycle.

Tick action (registered, same edge):
- lfsr <= SYM_BITS successive steps, unrolled combinationally.
- If sym_valid=0, or (sym_valid && sym_ready) in this cycle: sym_data <= new lfsr[SYM_BITS-1:0] and sym_valid <= 1.
- Otherwise the symbol is dropped, the LFSR still advances, and overrun_count increments, saturating at 16'hFFFF.

Handshake:
- A transfer occurs when sym_valid && sym_ready.
- With no tick in that cycle, sym_valid <= 0.
- sym_data is stable while sym_valid && !sym_ready.

Latency:
- First symbol: sym_valid rises eff_limit cycles after the first RUN cycle.
- Throughput: one symbol per eff_limit cycles. rate_limit=1 gives one per cycle, sustained with sym_ready=1.

Seed load (priority: reset > seed_load > tick):
- lfsr <= seed, or INIT_VAL if seed==0; seed==0 also sets lockup_err.
- counter <= 0, sym_valid <= 0, and the tick in that cycle is suppressed.
- FSM state is unchanged.

Lockup guard:
- If the LFSR state is ever 0, the next step yields INIT_VAL.
- lockup_err clears only on reset.

Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).

Decomposition:
- Package lfsr_sym_pkg: FSM enum {IDLE, RUN}; function lfsr_step(state, taps) for one right-shift Fibonacci step.
- Sub-module rate_tick_gen: a generalised clock divider producing a one-cycle enable pulse instead of a divided clock. Inputs: clk, reset, run, rate_limit. Output: tick.
- Top level: FSM, LFSR unroll, output register, overrun counter.

Test Plan:
1. Defaults, rate_limit=4, enable=1, sym_ready=1 -> sym_valid pulses every 4 cycles. sym_data = 2'b00, 2'b10, 2'b00. lfsr_state = 01000, 10010, 10100.
2. Defaults, rate_limit=1, sym_ready=1 for 31 ticks -> lfsr_state returns to 00001 (period 31, gcd(2,31)=1); overrun_count=0.
3. sym_ready=0, rate_limit=2, 10 ticks -> first symbol held stable with sym_valid=1, overrun_count=9. Then sym_ready=1 for 1 cycle: transfer, and the next tick reloads.
4. seed_load with seed=0 mid-RUN -> lfsr_state=00001, lockup_err=1, sym_valid=0, counter restarts. lockup_err stays 1 until reset.
5. rate_limit changed 100->3 while counter=50 -> tick on the next cycle (>= rule), then every 3 cycles. rate_limit=0 -> tick every cycle.
6. reset asserted asynchronously mid-symbol (sym_valid=1, overrun_count=5) -> all outputs return to reset values before the next clk edge. enable=0 -> no further ticks.
